// File: rtl/pwm_duty_ramp_ctrl_pkg.sv
// Shared types and helpers for the PWM duty ramp controller family.
// Holds the ramp FSM state encoding and the PWM period helper.
// No logic; imported by the phase counter and the controller top.
package pwm_duty_ramp_ctrl_pkg;

  // Legacy-compatible raw state codes, reused as the enum values below.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    RAMP_UP   = ST_RAMP_UP,
    RAMP_DOWN = ST_RAMP_DOWN
  } state_e;

  // PWM period in clocks for a given duty width (PERIOD_CLKS = 2**w).
  function automatic int period_clks(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_ctrl_phase_cnt.sv
// Free-running PWM phase counter: flags the last clock and first clock of each period.
// Latency: outputs are decoded combinationally from the registered phase.
// No backpressure: the counter never stalls, which keeps it aligned with the generator.
module pwm_phase_cnt
  import pwm_duty_ramp_ctrl_pkg::*;
#(
  parameter int W = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic wrap_o,
  output logic period_start_o
);

  localparam logic [W-1:0] LAST_PHASE = W'(period_clks(W) - 1);

  logic [W-1:0] phase;

  // Count 0..PERIOD_CLKS-1 and wrap; natural binary rollover gives the wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase <= '0;
    end else begin
      phase <= phase + W'(1);
    end
  end

  assign wrap_o         = (phase == LAST_PHASE);
  assign period_start_o = (phase == '0);

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Ramps the PWM duty one LSB per STEP_PERIODS periods toward an accepted target.
// Latency: first duty change lands STEP_PERIODS period boundaries after accept.
// Backpressure: tgt_ready_o low while ramping; requester holds tgt_valid_i, no queue.
module pwm_duty_ramp_ctrl
  import pwm_duty_ramp_ctrl_pkg::*;
#(
  parameter int DUTY_W       = 3,
  parameter int STEP_PERIODS = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              tgt_valid_i,
  input  logic [DUTY_W-1:0] tgt_duty_i,
  output logic              tgt_ready_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic              period_start_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int SC_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_PERIODS - 1);

  state_e            state;
  logic [DUTY_W-1:0] target;
  logic [SC_W-1:0]   step_cnt;
  logic              wrap;
  logic [DUTY_W-1:0] next_duty;
  logic              step_now;

  pwm_phase_cnt #(
    .W(DUTY_W)
  ) u_phase (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .wrap_o         (wrap),
    .period_start_o (period_start_o)
  );

  // Candidate duty for the next step; direction follows the ramp state.
  always_comb begin
    next_duty = duty_o;
    if (state == RAMP_UP) begin
      next_duty = duty_o + DUTY_W'(1);
    end else if (state == RAMP_DOWN) begin
      next_duty = duty_o - DUTY_W'(1);
    end
  end

  // A frozen ramp (enable low) ignores wraps entirely, so step_cnt resumes where it stopped.
  assign step_now = enable_i && wrap && (state != IDLE);

  // Ramp FSM, step counter and live duty. Duty only moves on a wrap edge,
  // so the new value first appears on the phase-0 clock of the next period.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      target   <= '0;
      step_cnt <= '0;
      duty_o   <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid_i) begin
            target   <= tgt_duty_i;
            step_cnt <= '0;
            if (tgt_duty_i == duty_o) begin
              done_o <= 1'b1;
            end else if (tgt_duty_i > duty_o) begin
              state <= RAMP_UP;
            end else begin
              state <= RAMP_DOWN;
            end
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (step_now) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              duty_o   <= next_duty;
              if (next_duty == target) begin
                state  <= IDLE;
                done_o <= 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + SC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tgt_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl with DUTY_W=3, STEP_PERIODS=4.
// Expected duty steps are queued when a target is sent and popped on each duty change.
// Outputs are sampled on the falling clock edge.
module tb_pwm_duty_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b1;
  logic       tgt_valid = 1'b0;
  logic [2:0] tgt_duty = 3'd0;
  logic       tgt_ready;
  logic [2:0] duty;
  logic       period_start;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int t_last = 0;
  int dc0;
  logic [2:0] ph = 3'd0;
  logic [2:0] exp_q[$];

  pwm_duty_ramp_ctrl #(
    .DUTY_W       (3),
    .STEP_PERIODS (4)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .enable_i       (enable),
    .tgt_valid_i    (tgt_valid),
    .tgt_duty_i     (tgt_duty),
    .tgt_ready_o    (tgt_ready),
    .duty_o         (duty),
    .period_start_o (period_start),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference phase: 8-clock period counter restarted by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= 3'd0;
    else        ph <= ph + 3'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // period_start must track the reference phase on every sampled clock.
  always @(negedge clk) begin
    chk("period_start", {31'd0, period_start}, {31'd0, (ph == 3'd0)});
    if (done) done_cnt++;
  end

  task automatic push_ramp(input int from, input int to);
    if (to > from) for (int v = from + 1; v <= to; v++) exp_q.push_back(3'(v));
    else           for (int v = from - 1; v >= to; v--) exp_q.push_back(3'(v));
  endtask

  // Offer a target, wait for ready, and return on the negedge after the accept edge.
  task automatic send(input logic [2:0] d);
    int n;
    n = 0;
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_duty  = d;
    while (!tgt_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, tgt_ready}, 32'd1);
    @(negedge clk);
    t_last    = cyc;
    tgt_valid = 1'b0;
  endtask

  // Consume queued duty steps; optionally freeze the ramp for 20 clocks before step gap_idx.
  task automatic ramp_wait(input int gap_idx, input bit final_done);
    int k;
    int n;
    int dt;
    logic [2:0] e;
    logic [2:0] last;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last = duty;
      n = 0;
      if (k == gap_idx) begin
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("gap_hold", {29'd0, duty}, {29'd0, last});
        enable = 1'b1;
      end
      do begin
        @(negedge clk);
        n++;
      end while (duty === last && n < 200);
      chk("step_val", {29'd0, duty}, {29'd0, e});
      chk("step_on_ps", {31'd0, period_start}, 32'd1);
      dt = cyc - t_last;
      t_last = cyc;
      if (k == 0) chk("first_lat", {31'd0, (dt >= 25 && dt <= 32)}, 32'd1);
      else        chk("step_gap", dt, (k == gap_idx) ? 32'd56 : 32'd32);
      if (exp_q.size() == 0 && final_done) begin
        chk("end_done", {31'd0, done}, 32'd1);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_ready", {31'd0, tgt_ready}, 32'd1);
      end else begin
        chk("mid_done", {31'd0, done}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_ready", {31'd0, tgt_ready}, 32'd0);
      end
      k++;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", {29'd0, duty}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_duty", {29'd0, duty}, 32'd0);
    chk("idle_ready", {31'd0, tgt_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 0 -> 5
    dc0 = done_cnt;
    send(3'd5);
    chk("acc_busy", {31'd0, busy}, 32'd1);
    push_ramp(0, 5);
    ramp_wait(-1, 1'b1);
    @(negedge clk);
    chk("done_single_up", done_cnt - dc0, 32'd1);
    chk("done_low_up", {31'd0, done}, 32'd0);

    // 5 -> 2
    dc0 = done_cnt;
    send(3'd2);
    push_ramp(5, 2);
    ramp_wait(-1, 1'b1);
    @(negedge clk);
    chk("done_single_dn", done_cnt - dc0, 32'd1);

    // 2 -> 3, then equal target 3
    send(3'd3);
    push_ramp(2, 3);
    ramp_wait(-1, 1'b1);
    send(3'd3);
    chk("eq_done", {31'd0, done}, 32'd1);
    chk("eq_busy", {31'd0, busy}, 32'd0);
    chk("eq_duty", {29'd0, duty}, 32'd3);
    @(negedge clk);
    chk("eq_done_low", {31'd0, done}, 32'd0);
    chk("eq_busy_low", {31'd0, busy}, 32'd0);

    // Fresh reset, 0 -> 7 with enable gap and a request held throughout
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(3'd7);
    tgt_valid = 1'b1;
    tgt_duty  = 3'd2;
    push_ramp(0, 7);
    ramp_wait(1, 1'b1);
    @(negedge clk);
    t_last = cyc;
    tgt_valid = 1'b0;
    chk("held_acc_busy", {31'd0, busy}, 32'd1);
    chk("held_acc_duty", {29'd0, duty}, 32'd7);

    // 7 -> 2 interrupted by reset at duty 4
    push_ramp(7, 4);
    ramp_wait(-1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_duty", {29'd0, duty}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd2);
    push_ramp(0, 2);
    ramp_wait(-1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
